vga_sprite_compositor: RTL and testbench

- Parametrised successor to the single-sprite VGA output stage.
- Composites NUM_SPRITES solid-colour rectangular sprites, in priority order, over a background colour stream supplied by the tile drawer.
- Sprite positions are double-buffered per frame so a frame never tears.
- Delays hsync, vsync and display_enable through the same 3-stage pipeline as colour, and blanks colour outside the active area.
- Sits between the timing generator/tile drawer and the board VGA pins.

---
 rtl/vga_sprite_compositor.sv | 153 +++++++++++++++
 tb/tb_vga_sprite_compositor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_compositor.sv
// VGA output stage: priority-composites NUM_SPRITES solid rectangles over the tile
// background, with sprite state double-buffered once per frame and a 3-stage aligned pipeline.
module vga_sprite_compositor #(
    parameter int NUM_SPRITES      = 3,
    parameter int COLOR_BITS       = 4,
    parameter int SPRITE_W         = 42,
    parameter int SPRITE_H         = 42,
    parameter int LATCH_ROW        = 480,
    parameter int BLINK_SHIFT      = 3,
    parameter int SYNC_ACTIVE_LOW  = 1,
    parameter int HEARTBEAT_CYCLES = 2500000
) (
    input  logic                                vga_clock,
    input  logic                                reset,
    input  logic [9:0]                          row,
    input  logic [9:0]                          column,
    input  logic                                display_enable,
    input  logic                                hsync_in,
    input  logic                                vsync_in,
    input  logic [COLOR_BITS-1:0]               bg_red,
    input  logic [COLOR_BITS-1:0]               bg_green,
    input  logic [COLOR_BITS-1:0]               bg_blue,
    input  logic [NUM_SPRITES*10-1:0]           sprite_x,
    input  logic [NUM_SPRITES*10-1:0]           sprite_y,
    input  logic [NUM_SPRITES-1:0]              sprite_enable,
    input  logic [NUM_SPRITES-1:0]              sprite_blink,
    input  logic [NUM_SPRITES*3*COLOR_BITS-1:0] sprite_rgb,
    output logic [COLOR_BITS-1:0]               vga_red,
    output logic [COLOR_BITS-1:0]               vga_green,
    output logic [COLOR_BITS-1:0]               vga_blue,
    output logic                                vga_hsync,
    output logic                                vga_vsync,
    output logic [15:0]                         frame_count,
    output logic                                heartbeat
);
    localparam int   RGB_W     = 3 * COLOR_BITS;
    localparam int   HB_W      = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
    localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

    logic [NUM_SPRITES*10-1:0]    shadow_x, shadow_y;
    logic [NUM_SPRITES-1:0]       shadow_en, shadow_blink;
    logic [NUM_SPRITES*RGB_W-1:0] shadow_rgb;
    logic [HB_W-1:0]              hb_count;
    logic                         latch;

    logic [NUM_SPRITES-1:0] hit_c, hit_p1;
    logic [RGB_W-1:0]       rgb_p1, sel_rgb, rgb_p2;
    logic                   vld_p1, vld_p2;
    logic                   hsync_p1, hsync_p2, vsync_p1, vsync_p2;

    assign latch = (row == 10'(LATCH_ROW)) && (column == 10'd0);

    always_ff @(posedge vga_clock) begin
        if (!reset) begin
            shadow_x     <= '0;
            shadow_y     <= '0;
            shadow_en    <= '0;
            shadow_blink <= '0;
            shadow_rgb   <= '0;
            frame_count  <= '0;
        end else if (latch) begin
            shadow_x     <= sprite_x;
            shadow_y     <= sprite_y;
            shadow_en    <= sprite_enable;
            shadow_blink <= sprite_blink;
            shadow_rgb   <= sprite_rgb;
            frame_count  <= frame_count + 16'd1;
        end
    end

    always_ff @(posedge vga_clock) begin
        if (!reset) begin
            hb_count  <= '0;
            heartbeat <= 1'b0;
        end else if (hb_count == HB_W'(HEARTBEAT_CYCLES - 1)) begin
            hb_count  <= '0;
            heartbeat <= ~heartbeat;
        end else begin
            hb_count  <= hb_count + 1'b1;
        end
    end

    // Stage 1: per-sprite hit test in 11 bits so right/bottom edges clip instead of wrapping
    always_comb begin
        hit_c = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            hit_c[i] = shadow_en[i]
                     & ~(shadow_blink[i] & frame_count[BLINK_SHIFT])
                     & ({1'b0, column} >= {1'b0, shadow_x[10*i +: 10]})
                     & ({1'b0, column} <  ({1'b0, shadow_x[10*i +: 10]} + 11'(SPRITE_W)))
                     & ({1'b0, row}    >= {1'b0, shadow_y[10*i +: 10]})
                     & ({1'b0, row}    <  ({1'b0, shadow_y[10*i +: 10]} + 11'(SPRITE_H)));
        end
    end

    always_ff @(posedge vga_clock) begin
        hit_p1 <= hit_c;
        rgb_p1 <= {bg_red, bg_green, bg_blue};
    end

    always_ff @(posedge vga_clock) begin
        if (!reset) begin
            vld_p1   <= 1'b0;
            hsync_p1 <= SYNC_IDLE;
            vsync_p1 <= SYNC_IDLE;
        end else begin
            vld_p1   <= display_enable;
            hsync_p1 <= hsync_in;
            vsync_p1 <= vsync_in;
        end
    end

    // Stage 2: lowest-index hit wins; scanning downward lets the lowest index overwrite last
    always_comb begin
        sel_rgb = rgb_p1;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_p1[i]) sel_rgb = shadow_rgb[RGB_W*i +: RGB_W];
        end
    end

    always_ff @(posedge vga_clock) begin
        rgb_p2 <= sel_rgb;
    end

    always_ff @(posedge vga_clock) begin
        if (!reset) begin
            vld_p2   <= 1'b0;
            hsync_p2 <= SYNC_IDLE;
            vsync_p2 <= SYNC_IDLE;
        end else begin
            vld_p2   <= vld_p1;
            hsync_p2 <= hsync_p1;
            vsync_p2 <= vsync_p1;
        end
    end

    // Stage 3: blank outside the active area and drive the pins
    always_ff @(posedge vga_clock) begin
        if (!reset) begin
            vga_red   <= '0;
            vga_green <= '0;
            vga_blue  <= '0;
            vga_hsync <= SYNC_IDLE;
            vga_vsync <= SYNC_IDLE;
        end else begin
            vga_red   <= vld_p2 ? rgb_p2[RGB_W-1 -: COLOR_BITS]        : '0;
            vga_green <= vld_p2 ? rgb_p2[2*COLOR_BITS-1 -: COLOR_BITS] : '0;
            vga_blue  <= vld_p2 ? rgb_p2[COLOR_BITS-1:0]               : '0;
            vga_hsync <= hsync_p2;
            vga_vsync <= vsync_p2;
        end
    end
endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Directed bench for vga_sprite_compositor: a frame-level model checked every cycle,
// plus literal pixel, frame counter and heartbeat expectations.
module tb_vga_sprite_compositor;
    localparam int NS = 3;
    localparam int CB = 4;
    localparam int HB = 10;

    logic              vga_clock = 1'b0;
    logic              reset;
    logic [9:0]        row, column;
    logic              display_enable, hsync_in, vsync_in;
    logic [CB-1:0]     bg_red, bg_green, bg_blue;
    logic [NS*10-1:0]  sprite_x, sprite_y;
    logic [NS-1:0]     sprite_enable, sprite_blink;
    logic [NS*3*CB-1:0] sprite_rgb;
    logic [CB-1:0]     vga_red, vga_green, vga_blue;
    logic              vga_hsync, vga_vsync;
    logic [15:0]       frame_count;
    logic              heartbeat;

    int total = 0;
    int bad   = 0;
    int frames = 0;

    vga_sprite_compositor #(.NUM_SPRITES(NS), .COLOR_BITS(CB), .HEARTBEAT_CYCLES(HB)) dut (
        .vga_clock(vga_clock), .reset(reset), .row(row), .column(column),
        .display_enable(display_enable), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_enable(sprite_enable),
        .sprite_blink(sprite_blink), .sprite_rgb(sprite_rgb),
        .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .frame_count(frame_count), .heartbeat(heartbeat)
    );

    always #5 vga_clock = ~vga_clock;

    // Model: the frame's sprite list, and the output seen after each edge being the
    // pixel presented two edges earlier (or the idle values while reset is flushing).
    localparam logic [13:0] RST_OUT = {12'h000, 1'b1, 1'b1};
    int          m_x[NS], m_y[NS];
    logic        m_en[NS], m_bl[NS];
    logic [11:0] m_rgb[NS];
    int          m_fc = 0;
    int          m_hb = 0;
    logic        m_init = 1'b0;
    logic [13:0] pipe[3];

    always @(posedge vga_clock) begin
        logic [11:0] colour;
        logic        found;
        int          c, r;
        if (!reset) begin
            for (int i = 0; i < 3; i++) pipe[i] = RST_OUT;
            for (int i = 0; i < NS; i++) begin
                m_x[i] = 0; m_y[i] = 0; m_en[i] = 0; m_bl[i] = 0; m_rgb[i] = '0;
            end
            m_fc = 0;
            m_hb = 0;
            m_init = 1'b1;
        end else begin
            c = int'(column);
            r = int'(row);
            colour = {bg_red, bg_green, bg_blue};
            found = 1'b0;
            for (int i = 0; i < NS; i++) begin
                if (!found && m_en[i] && !(m_bl[i] && (((m_fc >> 3) & 1) == 1)) &&
                    c >= m_x[i] && c < m_x[i] + 42 && r >= m_y[i] && r < m_y[i] + 42) begin
                    colour = m_rgb[i];
                    found = 1'b1;
                end
            end
            if (!display_enable) colour = '0;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = {colour, hsync_in, vsync_in};
            if (r == 480 && c == 0) begin
                for (int i = 0; i < NS; i++) begin
                    m_x[i]   = int'(sprite_x[10*i +: 10]);
                    m_y[i]   = int'(sprite_y[10*i +: 10]);
                    m_en[i]  = sprite_enable[i];
                    m_bl[i]  = sprite_blink[i];
                    m_rgb[i] = sprite_rgb[12*i +: 12];
                end
                m_fc = (m_fc + 1) & 32'hFFFF;
            end
            m_hb++;
        end
    end

    always @(negedge vga_clock) begin
        if (m_init) begin
            total++;
            if ({vga_red, vga_green, vga_blue, vga_hsync, vga_vsync} !== pipe[2] ||
                frame_count !== 16'(m_fc) || heartbeat !== 1'((m_hb / HB) % 2)) begin
                bad++;
                $display("FAIL model_cycle t=%0t: got rgb=%h hs=%b vs=%b fc=%h hb=%b, want rgb=%h hs=%b vs=%b fc=%h hb=%b",
                         $time, {vga_red, vga_green, vga_blue}, vga_hsync, vga_vsync, frame_count, heartbeat,
                         pipe[2][13:2], pipe[2][1], pipe[2][0], 16'(m_fc), 1'((m_hb / HB) % 2));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge vga_clock);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic set_sprite(input int i, input int x, input int y, input logic en,
                              input logic bl, input logic [11:0] rgb);
        sprite_x[10*i +: 10] = 10'(x);
        sprite_y[10*i +: 10] = 10'(y);
        sprite_enable[i]     = en;
        sprite_blink[i]      = bl;
        sprite_rgb[12*i +: 12] = rgb;
    endtask

    task automatic pix(input string name, input int r, input int c, input logic de,
                       input logic [11:0] want);
        row = 10'(r);
        column = 10'(c);
        display_enable = de;
        step(3);
        chk(name, 32'({vga_red, vga_green, vga_blue}), 32'(want));
    endtask

    task automatic latch_n(input int n);
        row = 10'd480;
        column = 10'd0;
        display_enable = 1'b0;
        step(n);
        frames = (frames + n) & 32'hFFFF;
    endtask

    initial begin
        reset = 1'b0;
        row = '0; column = '0; display_enable = 1'b1;
        hsync_in = 1'b1; vsync_in = 1'b1;
        bg_red = 4'h3; bg_green = 4'h5; bg_blue = 4'h7;
        sprite_x = '0; sprite_y = '0; sprite_enable = '0; sprite_blink = '0; sprite_rgb = '0;
        step(5);

        reset = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        step(1);
        chk("rst_c1_rgb", 32'({vga_red, vga_green, vga_blue}), 32'h000);
        chk("rst_c1_sync", 32'({vga_hsync, vga_vsync}), 32'b11);
        chk("rst_fc", 32'(frame_count), 0);
        chk("rst_hb", 32'(heartbeat), 0);
        step(1);
        chk("rst_c2_rgb", 32'({vga_red, vga_green, vga_blue}), 32'h000);
        chk("rst_c2_sync", 32'({vga_hsync, vga_vsync}), 32'b11);
        step(1);
        chk("rst_c3_rgb", 32'({vga_red, vga_green, vga_blue}), 32'h357);
        chk("rst_c3_sync", 32'({vga_hsync, vga_vsync}), 32'b00);
        hsync_in = 1'b1; vsync_in = 1'b1;

        set_sprite(0, 100, 50, 1'b1, 1'b0, 12'hF00);
        pix("pre_latch_bg", 50, 100, 1'b1, 12'h357);
        latch_n(1);
        pix("s0_corner", 50, 100, 1'b1, 12'hF00);
        pix("s0_col141", 50, 141, 1'b1, 12'hF00);
        pix("s0_col142", 50, 142, 1'b1, 12'h357);
        pix("s0_col99",  50, 99,  1'b1, 12'h357);
        pix("s0_row91",  91, 100, 1'b1, 12'hF00);
        pix("s0_row92",  92, 100, 1'b1, 12'h357);

        set_sprite(0, 200, 200, 1'b1, 1'b0, 12'hF00);
        set_sprite(1, 200, 200, 1'b1, 1'b0, 12'h0F0);
        latch_n(1);
        pix("prio_s0", 200, 200, 1'b1, 12'hF00);
        set_sprite(0, 200, 200, 1'b0, 1'b0, 12'hF00);
        pix("prio_no_latch", 200, 200, 1'b1, 12'hF00);
        latch_n(1);
        pix("prio_s1", 200, 200, 1'b1, 12'h0F0);

        row = 10'd100;
        set_sprite(1, 300, 200, 1'b1, 1'b0, 12'h0F0);
        pix("mid_old_pos", 200, 200, 1'b1, 12'h0F0);
        pix("mid_new_pos", 200, 300, 1'b1, 12'h357);
        latch_n(1);
        pix("next_new_pos", 200, 300, 1'b1, 12'h0F0);
        pix("next_old_pos", 200, 200, 1'b1, 12'h357);

        set_sprite(1, 300, 200, 1'b0, 1'b0, 12'h0F0);
        set_sprite(2, 620, 10, 1'b1, 1'b0, 12'h00F);
        latch_n(1);
        pix("clip_620", 10, 620, 1'b1, 12'h00F);
        pix("clip_639", 10, 639, 1'b1, 12'h00F);
        pix("clip_0",   10, 0,   1'b1, 12'h357);
        pix("clip_21",  10, 21,  1'b1, 12'h357);
        pix("blank_hit", 10, 630, 1'b0, 12'h000);

        set_sprite(2, 620, 10, 1'b1, 1'b1, 12'h00F);
        for (int k = 0; k < 16; k++) begin
            latch_n(1);
            chk("blink_fc", 32'(frame_count), 32'(frames));
            pix("blink_pix", 10, 625, 1'b1, ((frames >> 3) & 1) == 1 ? 12'h357 : 12'h00F);
        end

        latch_n(65535 - frames);
        chk("fc_ffff", 32'(frame_count), 32'hFFFF);
        latch_n(1);
        chk("fc_wrap", 32'(frame_count), 0);

        set_sprite(2, 620, 10, 1'b1, 1'b0, 12'h00F);
        reset = 1'b0;
        row = 10'd480; column = 10'd0; display_enable = 1'b0;
        step(4);
        reset = 1'b1;
        row = 10'd10; column = 10'd625; display_enable = 1'b1;
        step(3);
        chk("rst_latch_ignored_pix", 32'({vga_red, vga_green, vga_blue}), 32'h357);
        chk("rst_latch_ignored_fc", 32'(frame_count), 0);
        step(6);
        chk("hb_9", 32'(heartbeat), 0);
        step(1);
        chk("hb_10", 32'(heartbeat), 1);
        step(9);
        chk("hb_19", 32'(heartbeat), 1);
        step(1);
        chk("hb_20", 32'(heartbeat), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
